// File: rtl/mem_arbiter.sv
// Main-memory arbiter and cache-fill sequencer: serves one I/D fill burst or
// one D write-through at a time on a pipelined, fixed-latency memory.
module mem_arbiter #(
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_miss,
    input  logic [15:0]              i_addr,
    input  logic                     d_miss,
    input  logic [15:0]              d_addr,
    input  logic                     d_wr,
    input  logic [15:0]              d_wdata,
    output logic                     mem_en,
    output logic                     mem_wr,
    output logic [15:0]              mem_addr,
    output logic [15:0]              mem_wdata,
    input  logic [15:0]              mem_rdata,
    input  logic                     mem_valid,
    output logic                     fill_we,
    output logic                     fill_sel,
    output logic [$clog2(WORDS)-1:0] fill_word,
    output logic [15:0]              fill_data,
    output logic                     fill_tag_we,
    output logic                     i_done,
    output logic                     d_done,
    output logic                     busy
);

    localparam int WB = $clog2(WORDS);

    generate
        if (WORDS < 2 || WORDS != (1 << WB) || MEM_LAT < 1) begin : g_param_check
            $error("mem_arbiter: WORDS must be a power of 2 >= 2 and MEM_LAT >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t        state;
    logic          owner_d;
    logic [15:1]   addr_q;
    logic [15:0]   wdata_q;
    logic [WB:0]   issue_cnt;
    logic [WB-1:0] recv_cnt;
    logic          issuing;
    logic          unused_addr_lsb;

    // Byte-address LSBs are irrelevant to halfword-aligned memory accesses.
    assign unused_addr_lsb = i_addr[0] ^ d_addr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            fill_sel  <= 1'b0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_wr) begin
                        owner_d <= 1'b1;
                        addr_q  <= d_addr[15:1];
                        wdata_q <= d_wdata;
                        state   <= WRITE;
                    end else if (d_miss) begin
                        owner_d  <= 1'b1;
                        addr_q   <= d_addr[15:1];
                        wdata_q  <= d_wdata;
                        fill_sel <= 1'b1;
                        state    <= FILL;
                    end else if (i_miss) begin
                        owner_d  <= 1'b0;
                        addr_q   <= i_addr[15:1];
                        fill_sel <= 1'b0;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (!issue_cnt[WB])
                        issue_cnt <= issue_cnt + 1'b1;
                    if (mem_valid) begin
                        recv_cnt <= recv_cnt + 1'b1;
                        if (&recv_cnt)
                            state <= DONE;
                    end
                end
                WRITE: state <= DONE;
                DONE: begin
                    issue_cnt <= '0;
                    recv_cnt  <= '0;
                    fill_sel  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Issue side stops once the counter's top bit reaches WORDS.
    assign issuing = (state == FILL) && !issue_cnt[WB];

    always_comb begin
        mem_en    = issuing || (state == WRITE);
        mem_wr    = (state == WRITE);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == WRITE) begin
            mem_addr  = {addr_q, 1'b0};
            mem_wdata = wdata_q;
        end else if (issuing) begin
            mem_addr = {addr_q[15:WB+1], issue_cnt[WB-1:0], 1'b0};
        end
    end

    assign fill_we     = (state == FILL) && mem_valid;
    assign fill_word   = fill_we ? recv_cnt : '0;
    assign fill_data   = fill_we ? mem_rdata : '0;
    assign fill_tag_we = fill_we && (&recv_cnt);
    assign i_done      = (state == DONE) && !owner_d;
    assign d_done      = (state == DONE) && owner_d;
    assign busy        = (state != IDLE);

endmodule
